c1_step_sequencer: RTL and testbench
====================================

Name: c1_step_sequencer

Overview:
Sequences repeated runs of the c1 fluid kernel for a host-programmed number of time steps. Each step is one c1 run: one `i_run_req` pulse, then one `o_run_busy` high window.
- Issues a one-cycle run request per step and tracks the kernel busy handshake.
- Detects a kernel that never starts, supports a graceful abort, and reports steps completed and total cycles.
- Sits between the host/control register block and the c1 core, which it drives through its `ce` and `i_run_req` inputs.

Parameters:
- STEP_W, 16, width of step count request and report
- CYC_W, 32, width of elapsed-cycle counter (saturating)
- START_TIMEOUT, 64, max cycles from run request to busy rising before error
- GAP_CYCLES, 2, idle cycles inserted between busy falling and the next request (≥1)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle start pulse; honoured only in IDLE
- i_num_steps  in  STEP_W  steps to run; sampled on accepted i_start
- i_abort  in  1  abort request pulse; latched
- o_busy  out  1  high from accepted start until DONE/ERR exit
- o_done  out  1  one-cycle pulse on completion (normal or aborted)
- o_aborted  out  1  high with o_done if run ended by abort; held until next start
- o_error  out  1  sticky start-timeout flag; cleared by accepted start or reset
- o_step_count  out  STEP_W  completed steps in current/last job
- o_cycle_count  out  CYC_W  cycles from start accept to DONE, saturating
- o_kernel_ce  out  1  enable to c1 ce; high while o_busy
- o_run_req  out  1  to c1 i_run_req; one-cycle pulse per step
- i_run_busy  in  1  from c1 o_run_busy

Behaviour:
- Reset: state IDLE; all outputs 0; all counters and latches cleared. Reset mid-job abandons the job immediately; o_run_req and o_kernel_ce drop on the next cycle.
- States: IDLE, REQ, WAIT_BUSY, RUN, GAP, DONE, ERR.
- IDLE:
  - i_start=1 latches i_num_steps, clears step/cycle counters, o_error, o_aborted and abort latch.
  - Next state is REQ, or DONE if i_num_steps==0 (no request issued).
- REQ: o_run_req=1 for exactly this cycle; next state WAIT_BUSY; timeout counter cleared. If abort is latched on entry, go to DONE instead without issuing a request.
- WAIT_BUSY: on i_run_busy=1 go to RUN. After START_TIMEOUT cycles without busy, go to ERR. Abort is latched but not acted on here.
- RUN: wait for i_run_busy=0. On the fall, o_step_count increments in the same edge.
  - If the new count equals the target, or abort is latched → DONE.
  - Otherwise → GAP.
- GAP: hold GAP_CYCLES cycles, then REQ. A latched abort → DONE at the end of GAP.
- DONE: o_done=1 for one cycle; o_aborted=abort latch; next IDLE. o_busy is low in the DONE cycle.
- ERR: o_error=1 (sticky); o_done is not pulsed; next IDLE. o_step_count holds the steps completed before the fault.
- Latency, start to first request: i_start at edge N → o_run_req high in cycle N+1.
- Counter widths:
  - o_cycle_count increments every cycle state ∉ {IDLE, DONE, ERR} and saturates at all-ones.
  - o_step_count never wraps, since the target ≤ 2^STEP_W−1.
- Simultaneous events:
  - i_start outside IDLE is ignored.
  - i_abort in IDLE is ignored.
  - i_abort in the same cycle busy falls in RUN takes effect (→DONE, aborted).
  - i_run_busy high in REQ is ignored; only WAIT_BUSY samples the rise.
  - A kernel asserting busy in the cycle after the request is the normal case.

Decomposition:
- Package c1_seq_pkg holds the state enum encoding (IDLE..ERR) and default parameter constants.
- One natural sub-module: c1_seq_timer, a loadable down-counter with a zero flag, instantiated twice (start timeout and GAP delay).
- Counters and FSM stay in the top level.

Test Plan:
- Normal run: i_num_steps=3, kernel model busy 1 cycle after req for 10 cycles.
  - Required: exactly 3 o_run_req pulses spaced 2 gap cycles apart, then o_done once.
  - Required: o_step_count=3, o_aborted=0, o_error=0, o_cycle_count=3·(1+1+10)+2·2 ±1 per spec edges, checked exactly against the model.
- Zero steps: i_start with i_num_steps=0 → no o_run_req; o_done 1 cycle after start; o_step_count=0.
- Start timeout: kernel never raises busy → o_error=1 at START_TIMEOUT=64 cycles after the req; no o_done; o_busy low; next i_start clears o_error.
- Abort mid-run: i_num_steps=5, i_abort during step 2 busy → step 2 completes, no 3rd req, o_done with o_aborted=1, o_step_count=2.
- Reset mid-job: assert reset while in RUN → next cycle all outputs 0 and state IDLE; a fresh i_start with 1 step completes normally.
- Ignored inputs: i_start pulsed during RUN and i_abort pulsed in IDLE → no effect on counts or handshake.

Source files
------------

// File: rtl/c1_seq_pkg.sv
// Shared state encoding and default sizing for the c1 step sequencer.
package c1_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_BUSY, S_RUN, S_GAP, S_DONE, S_ERR
  } seq_state_e;

  localparam int DEF_STEP_W        = 16;
  localparam int DEF_CYC_W         = 32;
  localparam int DEF_START_TIMEOUT = 64;
  localparam int DEF_GAP_CYCLES    = 2;

  // States that belong to an active job (counted, o_busy high).
  function automatic logic in_job(seq_state_e s);
    return (s == S_REQ) || (s == S_WAIT_BUSY) || (s == S_RUN) || (s == S_GAP);
  endfunction

endpackage

// File: rtl/c1_seq_timer.sv
// Loadable down-counter that parks at zero; zero flag reflects the current count.
module c1_seq_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/c1_step_sequencer.sv
// Runs the c1 kernel for a programmed number of steps, one run request per step,
// with start-timeout detection, graceful abort and step/cycle reporting.
module c1_step_sequencer
  import c1_seq_pkg::*;
#(
  parameter int STEP_W        = DEF_STEP_W,
  parameter int CYC_W         = DEF_CYC_W,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_start,
  input  logic [STEP_W-1:0] i_num_steps,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic              o_error,
  output logic [STEP_W-1:0] o_step_count,
  output logic [CYC_W-1:0]  o_cycle_count,
  output logic              o_kernel_ce,
  output logic              o_run_req,
  input  logic              i_run_busy
);

  localparam int TO_W  = $clog2(START_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(START_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] tgt_q, tgt_d, step_q, step_d, step_inc;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              abort_q, abort_d, aborted_q, aborted_d, err_q, err_d;
  logic              run_req_q, run_req_d, busy_q, busy_d, done_q, done_d;
  logic              abort_eff, to_zero, gap_zero, to_load, gap_load;

  // The timeout window spans the REQ cycle plus WAIT_BUSY, so the load
  // happens on the edge that enters REQ.
  assign to_load  = (state_d == S_REQ) && (state_q != S_REQ);
  assign gap_load = (state_d == S_GAP) && (state_q != S_GAP);

  c1_seq_timer #(.W(TO_W)) u_start_to (
    .clock(clock), .reset(reset), .load(to_load), .load_val(TO_LOAD), .zero(to_zero)
  );

  c1_seq_timer #(.W(GAP_W)) u_gap (
    .clock(clock), .reset(reset), .load(gap_load), .load_val(GAP_LOAD), .zero(gap_zero)
  );

  assign abort_eff = abort_q | i_abort;
  assign step_inc  = step_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    cyc_d     = cyc_q;
    abort_d   = abort_q;
    aborted_d = aborted_q;
    err_d     = err_q;
    if (in_job(state_q)) begin
      abort_d = abort_eff;
      if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
    end
    case (state_q)
      S_IDLE: if (i_start) begin
        tgt_d     = i_num_steps;
        step_d    = '0;
        cyc_d     = '0;
        err_d     = 1'b0;
        aborted_d = 1'b0;
        abort_d   = 1'b0;
        state_d   = (i_num_steps == '0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        state_d = abort_q ? S_DONE : S_WAIT_BUSY;
        if (abort_q) aborted_d = 1'b1;
      end
      S_WAIT_BUSY: begin
        if (i_run_busy)   state_d = S_RUN;
        else if (to_zero) state_d = S_ERR;
      end
      S_RUN: if (!i_run_busy) begin
        step_d = step_inc;
        if ((step_inc == tgt_q) || abort_eff) begin
          state_d   = S_DONE;
          aborted_d = abort_eff;
        end else begin
          state_d = S_GAP;
        end
      end
      // Abort arriving in the last GAP cycle is honoured here, so REQ is
      // never entered with an abort already pending.
      S_GAP: if (gap_zero) begin
        state_d = abort_eff ? S_DONE : S_REQ;
        if (abort_eff) aborted_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERR) err_d = 1'b1;
    run_req_d = (state_d == S_REQ);
    busy_d    = in_job(state_d);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tgt_q     <= '0;
      step_q    <= '0;
      cyc_q     <= '0;
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      run_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      cyc_q     <= cyc_d;
      abort_q   <= abort_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
      run_req_q <= run_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_kernel_ce   = busy_q;
  assign o_done        = done_q;
  assign o_aborted     = aborted_q;
  assign o_error       = err_q;
  assign o_step_count  = step_q;
  assign o_cycle_count = cyc_q;
  assign o_run_req     = run_req_q;

endmodule

// File: tb/tb_c1_step_sequencer.sv
// Randomized scoreboard bench: a kernel model answers run requests, a job-level
// reference model predicts each job's outcome, and a monitor checks job ends.
module tb_c1_step_sequencer;

  localparam int STEP_W = 16;
  localparam int CYC_W  = 32;
  localparam int TO     = 64;
  localparam int GAP    = 2;
  localparam int NEVER  = 500;

  logic              clock, reset, i_start, i_run_busy, i_abort;
  logic              abort_k, abort_drv;
  logic [STEP_W-1:0] i_num_steps;
  logic              o_busy, o_done, o_aborted, o_error, o_kernel_ce, o_run_req;
  logic [STEP_W-1:0] o_step_count;
  logic [CYC_W-1:0]  o_cycle_count;

  assign i_abort = abort_k | abort_drv;

  c1_step_sequencer #(.STEP_W(STEP_W), .CYC_W(CYC_W), .START_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset(reset), .i_start(i_start), .i_num_steps(i_num_steps),
    .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
    .o_error(o_error), .o_step_count(o_step_count), .o_cycle_count(o_cycle_count),
    .o_kernel_ce(o_kernel_ce), .o_run_req(o_run_req), .i_run_busy(i_run_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit     is_err;
    int     steps;
    bit     aborted;
    longint cycles;
    int     reqs;
  } exp_t;

  exp_t exp_q[$];
  int   ntest, nfail;
  int   dly_a[8];
  int   len_a[8];
  int   abort_step;

  task automatic chk(string name, longint act, longint req);
    ntest++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Job-level prediction: every completed step costs request + wait + busy
  // cycles, gaps separate steps, a kernel that is too slow costs TO cycles.
  function automatic exp_t model(int n, int ab);
    exp_t e;
    e = '{is_err: 0, steps: 0, aborted: 0, cycles: 0, reqs: 0};
    for (int k = 0; k < n; k++) begin
      if (k > 0) e.cycles += GAP;
      e.reqs++;
      if (dly_a[k] >= TO) begin
        e.cycles += TO;
        e.is_err = 1;
        break;
      end
      e.cycles += 1 + dly_a[k] + len_a[k];
      e.steps++;
      if (ab == k + 1) begin
        e.aborted = 1;
        break;
      end
    end
    return e;
  endfunction

  // Kernel model: busy rises dly cycles after the request and lasts len cycles.
  initial begin
    int kidx;
    kidx = 0; i_run_busy = 1'b0; abort_k = 1'b0;
    forever begin
      @(negedge clock);
      abort_k = 1'b0;
      if (reset || !o_busy) begin
        i_run_busy = 1'b0;
        kidx = 0;
      end else if (o_run_req) begin
        int d, l;
        bit ab, rst_seen;
        d = dly_a[kidx]; l = len_a[kidx]; ab = (abort_step == kidx + 1);
        kidx++;
        rst_seen = 0;
        if (d < NEVER) begin
          for (int j = 0; j < d; j++) begin
            @(negedge clock);
            if (reset) begin rst_seen = 1; break; end
          end
          if (!rst_seen) begin
            i_run_busy = 1'b1;
            abort_k = ab;
            for (int j = 0; j < l; j++) begin
              @(negedge clock);
              abort_k = 1'b0;
              if (reset) break;
            end
          end
          i_run_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops one expectation whenever a job ends (done pulse or error rise).
  initial begin
    int reqs;
    bit prev_err;
    exp_t e;
    reqs = 0; prev_err = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        reqs = 0; prev_err = 0;
        continue;
      end
      if (o_run_req) reqs++;
      if (o_done || (o_error && !prev_err)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_job_end", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("end_is_error", o_error, e.is_err);
          chk("end_done_pulse", o_done, !e.is_err);
          chk("end_step_count", o_step_count, e.steps);
          chk("end_cycle_count", o_cycle_count, e.cycles);
          chk("end_run_reqs", reqs, e.reqs);
          chk("end_busy_low", o_busy, 0);
          if (!e.is_err) chk("end_aborted", o_aborted, e.aborted);
        end
        reqs = 0;
      end
      prev_err = o_error;
    end
  end

  task automatic set_steps(int n, int d, int l);
    for (int k = 0; k < 8; k++) begin
      dly_a[k] = d; len_a[k] = l;
    end
  endtask

  task automatic run_job(input int n, input int ab, input bit poke, output int ncyc);
    int cyc;
    exp_q.push_back(model(n, ab));
    abort_step = ab;
    @(negedge clock);
    i_num_steps = STEP_W'(n);
    i_start = 1'b1;
    @(negedge clock);
    i_start = 1'b0;
    if (n == 0) begin
      chk("zero_done_latency", o_done, 1);
      chk("zero_no_req", o_run_req, 0);
    end else begin
      chk("req_latency", o_run_req, 1);
    end
    chk("start_clears_error", o_error, 0);
    cyc = 0;
    while ((o_busy || o_done) && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      if (poke && cyc == 20 && o_busy) begin
        i_start = 1'b1; i_num_steps = 16'd7;
      end else begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    if (cyc >= 4000) chk("job_timeout", 1, 0);
    ncyc = cyc;
    @(negedge clock);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_aborted"}, o_aborted, 0);
    chk({tag, "_error"}, o_error, 0);
    chk({tag, "_steps"}, o_step_count, 0);
    chk({tag, "_cycles"}, o_cycle_count, 0);
    chk({tag, "_ce"}, o_kernel_ce, 0);
    chk({tag, "_req"}, o_run_req, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=stuck required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc, n, ab;
    ntest = 0; nfail = 0;
    reset = 1'b1; i_start = 1'b0; i_num_steps = '0; abort_drv = 1'b0; abort_step = 0;
    set_steps(8, 1, 10);
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;

    // Normal three-step run, then zero steps.
    set_steps(8, 1, 10);
    run_job(3, 0, 0, ncyc);
    run_job(0, 0, 0, ncyc);

    // Kernel never starts: error 64 cycles after the request.
    set_steps(8, NEVER, 1);
    run_job(1, 0, 0, ncyc);
    chk("timeout_latency", ncyc, TO);
    chk("timeout_error_sticky", o_error, 1);
    chk("timeout_done_low", o_done, 0);

    // Abort during the second step's busy window; next start clears the error.
    set_steps(8, 1, 10);
    run_job(5, 2, 0, ncyc);

    // Abort in IDLE is ignored.
    @(negedge clock); abort_drv = 1'b1;
    @(negedge clock); abort_drv = 1'b0;
    run_job(2, 0, 0, ncyc);

    // Start pulsed mid-run is ignored.
    set_steps(8, 1, 30);
    run_job(2, 0, 1, ncyc);

    // Reset in RUN abandons the job; a fresh one-step job completes.
    set_steps(8, 1, 20);
    @(negedge clock);
    i_num_steps = 16'd3; i_start = 1'b1;
    @(negedge clock); i_start = 1'b0;
    repeat (6) @(negedge clock);
    chk("pre_reset_in_run", i_run_busy & o_busy, 1);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("midreset");
    @(negedge clock);
    reset = 1'b0;
    set_steps(8, 2, 5);
    run_job(1, 0, 0, ncyc);

    // Random jobs.
    for (int j = 0; j < 12; j++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) begin
        dly_a[k] = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 6);
        len_a[k] = $urandom_range(1, 12);
      end
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      run_job(n, ab, 0, ncyc);
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
